// File: rtl/msrv32_machine_control.sv
// Machine-mode trap/return controller: decodes ECALL/EBREAK/MRET, prioritises
// exceptions over enabled interrupts, and drives PC select, flush and CSR strobes.
module msrv32_machine_control (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       illegal_instr_in,
  input  logic       misaligned_load_in,
  input  logic       misaligned_store_in,
  input  logic       misaligned_instr_in,
  input  logic [4:0] opcode_6_to_2_in,
  input  logic [2:0] funct3_in,
  input  logic [6:0] funct7_in,
  input  logic [4:0] rs2_addr_in,
  input  logic       mie_in,
  input  logic       meie_in,
  input  logic       mtie_in,
  input  logic       msie_in,
  input  logic       meip_in,
  input  logic       mtip_in,
  input  logic       msip_in,
  output logic [1:0] pc_src_out,
  output logic       flush_out,
  output logic       trap_taken_out,
  output logic       i_or_e_out,
  output logic [3:0] cause_out,
  output logic       set_cause_out,
  output logic       set_epc_out,
  output logic       mie_clear_out,
  output logic       mie_set_out,
  output logic       instret_inc_out
);

  typedef enum logic [1:0] {
    RESET       = 2'b00,
    OPERATING   = 2'b01,
    TRAP_TAKEN  = 2'b10,
    TRAP_RETURN = 2'b11
  } state_t;

  state_t     state, state_nxt, state_tgt;
  logic       is_system, is_ecall, is_ebreak, is_mret;
  logic       exc_pend, irq_pend;
  logic [3:0] cause_nxt;

  always_comb begin
    is_system = (opcode_6_to_2_in == 5'b11100) && (funct3_in == 3'b000);
    is_ecall  = is_system && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'd0);
    is_ebreak = is_system && (funct7_in == 7'b0000000) && (rs2_addr_in == 5'd1);
    is_mret   = is_system && (funct7_in == 7'b0011000) && (rs2_addr_in == 5'd2);
    exc_pend  = misaligned_instr_in | illegal_instr_in | is_ecall | is_ebreak |
                misaligned_load_in | misaligned_store_in;
    irq_pend  = mie_in & ((meie_in & meip_in) | (msie_in & msip_in) | (mtie_in & mtip_in));

    // Exceptions first, then interrupts; each list is in descending priority.
    cause_nxt = 4'd0;
    if (misaligned_instr_in)         cause_nxt = 4'd0;
    else if (illegal_instr_in)       cause_nxt = 4'd2;
    else if (is_ebreak)              cause_nxt = 4'd3;
    else if (is_ecall)               cause_nxt = 4'd11;
    else if (misaligned_load_in)     cause_nxt = 4'd4;
    else if (misaligned_store_in)    cause_nxt = 4'd6;
    else if (meie_in & meip_in)      cause_nxt = 4'd11;
    else if (msie_in & msip_in)      cause_nxt = 4'd3;
    else if (mtie_in & mtip_in)      cause_nxt = 4'd7;

    state_nxt = OPERATING;
    case (state)
      OPERATING: begin
        if (exc_pend || irq_pend) state_nxt = TRAP_TAKEN;
        else if (is_mret)         state_nxt = TRAP_RETURN;
        else                      state_nxt = OPERATING;
      end
      default: state_nxt = OPERATING;
    endcase

    state_tgt = rst_n_in ? state_nxt : RESET;
  end

  // Outputs are registered from the state being entered, so they track state exactly.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state      <= RESET;
      cause_out  <= 4'd0;
      i_or_e_out <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == OPERATING && state_nxt == TRAP_TAKEN) begin
        cause_out  <= cause_nxt;
        i_or_e_out <= ~exc_pend;
      end
    end

    pc_src_out      <= state_tgt;
    flush_out       <= 1'b1;
    trap_taken_out  <= 1'b0;
    set_cause_out   <= 1'b0;
    set_epc_out     <= 1'b0;
    mie_clear_out   <= 1'b0;
    mie_set_out     <= 1'b0;
    instret_inc_out <= 1'b0;
    case (state_tgt)
      OPERATING: begin
        flush_out       <= 1'b0;
        instret_inc_out <= 1'b1;
      end
      TRAP_TAKEN: begin
        trap_taken_out <= 1'b1;
        set_cause_out  <= 1'b1;
        set_epc_out    <= 1'b1;
        mie_clear_out  <= 1'b1;
      end
      TRAP_RETURN: mie_set_out <= 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/msrv32_machine_control.md
Name: msrv32_machine_control

Overview:
Machine-mode trap/return controller for the MSRV32 core. It is the consumer of the decoder's exception flags (illegal_instr, misaligned_load, misaligned_store) and the producer of the trap_taken signal the decoder uses to squash register-file, CSR and memory writes. It also arbitrates enabled interrupts, decodes ECALL/EBREAK/MRET, and drives PC-source select, pipeline flush, and CSR update strobes for mcause, mepc and mstatus.MIE.

Parameters:
none (cause codes and PC-source encodings are fixed below)

Ports:
clk_in  input  1  core clock
rst_n_in  input  1  reset, synchronous, active-low
illegal_instr_in  input  1  from decoder
misaligned_load_in  input  1  from decoder
misaligned_store_in  input  1  from decoder
misaligned_instr_in  input  1  target-address bit 1 set on taken jump/branch
opcode_6_to_2_in  input  5  instr[6:2]
funct3_in  input  3  instr[14:12]
funct7_in  input  7  instr[31:25]
rs2_addr_in  input  5  instr[24:20]
mie_in  input  1  mstatus.MIE
meie_in, mtie_in, msie_in  input  1 each  mie.MEIE/MTIE/MSIE
meip_in, mtip_in, msip_in  input  1 each  external/timer/software pending
pc_src_out  output  2  00 boot, 01 next PC, 10 trap vector, 11 mepc
flush_out  output  1  kill instruction in fetch stage
trap_taken_out  output  1  to decoder
i_or_e_out  output  1  1 = interrupt, 0 = exception
cause_out  output  4  mcause code
set_cause_out, set_epc_out  output  1 each  CSR write strobes
mie_clear_out, mie_set_out  output  1 each  mstatus.MIE update strobes
instret_inc_out  output  1  minstret increment

Behaviour:
- Moore FSM; state register and cause/i_or_e registers update on posedge clk_in. rst_n_in=0 at an edge forces RESET and clears cause_out and i_or_e_out to 0, including mid-trap.
- System instruction decode: SYSTEM = (opcode_6_to_2_in==5'b11100 && funct3_in==000).
  - ECALL: SYSTEM, funct7=0, rs2=0.
  - EBREAK: SYSTEM, funct7=0, rs2=1.
  - MRET: SYSTEM, funct7=7'b0011000, rs2=2.
  - WFI and all other SYSTEM forms execute as NOP.
- Exception pending = misaligned_instr | illegal | ecall | ebreak | misaligned_load | misaligned_store.
- Interrupt pending = mie_in & ((meie&meip) | (msie&msip) | (mtie&mtip)).
- States and transitions:
  - RESET → OPERATING, unconditionally, on the first edge after rst_n_in=1.
  - OPERATING:
    - exception pending → TRAP_TAKEN
    - else interrupt pending → TRAP_TAKEN
    - else MRET → TRAP_RETURN
    - else stay in OPERATING
  - TRAP_TAKEN → OPERATING, always after exactly 1 cycle.
  - TRAP_RETURN → OPERATING, always after exactly 1 cycle.
- Cause capture happens on the edge leaving OPERATING for TRAP_TAKEN. Exceptions win over interrupts.
  - Exception priority and cause: misaligned_instr=0 > illegal=2 > ebreak=3 > ecall=11 > misaligned_load=4 > misaligned_store=6; i_or_e=0.
  - Interrupt priority and cause: external=11 > software=3 > timer=7; i_or_e=1.
  - cause_out and i_or_e_out hold their value until the next capture.
- Outputs, purely a function of state:
  - RESET: pc_src=00, flush=1; all strobes and trap_taken=0.
  - OPERATING: pc_src=01, flush=0, instret_inc=1; other strobes 0.
  - TRAP_TAKEN: pc_src=10, flush=1, trap_taken=1, set_cause=1, set_epc=1, mie_clear=1, instret_inc=0.
  - TRAP_RETURN: pc_src=11, flush=1, mie_set=1, instret_inc=0; trap_taken=0.
- Latency: a condition present in OPERATING cycle N produces TRAP state outputs in cycle N+1, and OPERATING resumes in cycle N+2.
- MRET that is also flagged illegal is an exception, not a return.
- Interrupts and MRET arriving while in TRAP_TAKEN or TRAP_RETURN are ignored. A still-pending interrupt is re-evaluated in the next OPERATING cycle; mie_in is expected low after mie_clear.

Test Plan:
1. Hold rst_n_in=0 for 3 cycles, then release → pc_src=00, flush=1, cause=0 during reset; one cycle later pc_src=01, instret_inc=1.
2. illegal_instr_in=1 for 1 cycle in OPERATING → next cycle trap_taken=1, pc_src=10, cause=2, i_or_e=0, set_epc=set_cause=mie_clear=1; following cycle pc_src=01.
3. misaligned_load_in=1 together with ECALL (opcode 11100, f3 0, f7 0, rs2 0) → cause=11; repeat with misaligned_store alone → cause=6.
4. mie_in=1, mtie=mtip=1, meie=meip=1 → cause=11, i_or_e=1; same stimulus with mie_in=0 → stays OPERATING, no trap.
5. MRET (f7 0011000, rs2 2) → next cycle pc_src=11, mie_set=1, flush=1, trap_taken=0; then OPERATING. MRET with illegal_instr=1 → TRAP_TAKEN with cause=2.
6. Drop rst_n_in to 0 in the TRAP_TAKEN cycle → next cycle RESET outputs, cause=0; no further set_epc pulse.
